hazard_issue_ctrl: RTL
======================

// Module: hazard_issue_ctrl
// PURPOSE
//  Pipeline interlock controller between decode (ID) and execute (EX).
//  Keeps a per-register scoreboard of outstanding writes and stalls ID on RAW/WAW hazards.
//  Sequences the multi-cycle multiplier (structural hazard on the ALU).
//  Generates the IF/ID flush window after an EX-stage PC redirect (jump/branch).
//  Sits beside the decode control block; consumes its reg_wen, type/op and pc_sel outputs.
// PARAMETERS
//  NREG      16  architectural registers tracked by the scoreboard
//  AW        4   register address width, clog2(NREG)
//  MUL_LAT   3   cycles the ALU is occupied by MUL/MULI, >=1
//  FLUSH_CYC 2   cycles flush_out is held after a redirect, >=1
//  ZERO_REG  1   1: register 0 is hardwired, never marked pending
// PORTS
//  clk_in        in   1      clock, rising edge
//  rst_n_in      in   1      async active-low reset
//  id_valid_in   in   1      valid instruction present in ID
//  id_rs1_in     in   AW     source 1 address
//  id_rs1_use_in in   1      rs1 is read by the instruction
//  id_rs2_in     in   AW     source 2 address
//  id_rs2_use_in in   1      rs2 is read by the instruction
//  id_rd_in      in   AW     destination address
//  id_wen_in     in   1      instruction writes rd (control reg_wen)
//  id_mul_in     in   1      instruction is MUL or MULI
//  redirect_in   in   1      EX-stage PC redirect (control pc_sel), 1-cycle pulse
//  wb_wen_in     in   1      writeback commits this cycle
//  wb_rd_in      in   AW     writeback destination
//  issue_out     out  1      ID instruction advances to EX this cycle (comb.)
//  stall_out     out  1      hold PC and IF/ID register (comb.)
//  flush_out     out  1      bubble IF/ID and ID/EX (registered)
//  mul_busy_out  out  1      multiplier occupying the ALU (registered)
//  pending_out   out  NREG   scoreboard contents (registered)
// BEHAVIOUR
//  Reset (async, rst_n_in=0): pending=0, mul_cnt=0, state=IDLE, flush_cnt=0.
//   All registered outputs read 0; comb outputs follow from that state.
//  Hazard (comb.): haz = id_valid & ((rs1_use & pend[rs1]) | (rs2_use & pend[rs2])
//   | (id_wen & pend[rd])) | (id_valid & mul_busy).
//   With ZERO_REG=1, address 0 never hits.
//  A source matching wb_rd_in with wb_wen_in=1 in the same cycle counts as NOT pending.
//   Writeback bypass is assumed to exist in the datapath.
//  Priority, highest first: redirect_in, then FLUSH state, then haz.
//   issue_out = id_valid & ~redirect_in & (state==IDLE) & ~haz.
//   stall_out = id_valid & ~redirect_in & (state==IDLE) & haz.
//  Scoreboard update each edge: clear bit wb_rd if wb_wen.
//   Set bit id_rd if issue & id_wen (and rd!=0 when ZERO_REG).
//   Same register set and cleared in one cycle: set wins.
//  MUL: issue & id_mul loads mul_cnt=MUL_LAT-1; otherwise mul_cnt decrements to 0.
//   mul_busy_out = (mul_cnt!=0). With MUL_LAT=1 it never asserts.
//  FSM IDLE -> FLUSH on redirect_in, loading flush_cnt=FLUSH_CYC-1; flush_out=1 while in FLUSH.
//   FLUSH decrements flush_cnt; at 0 it returns to IDLE.
//   redirect_in while in FLUSH reloads flush_cnt (window restarts).
//  Redirect does not clear pending bits; older in-flight writes still write back.
//  Reset mid-operation: all state discarded immediately; scoreboard is empty after release.
// TESTING
//  T1 RAW: issue wen rd=5; next ID rs1=5 use=1 -> stall_out=1 until wb_wen rd=5.
//     Issue in that wb cycle; pending[5] then 0.
//  T2 set/clear collide: pend[3]=1; wb rd=3 and issue wen rd=3 in the same cycle
//     -> pending[3]=1 after the edge.
//  T3 MUL: MUL_LAT=3, issue MUL, then back-to-back ALU ops
//     -> mul_busy 2 cycles, 2 stall cycles, issue on the 3rd cycle.
//  T4 redirect: redirect_in pulse, id_valid=1 -> issue=0, flush_out=1 for 2 cycles.
//     Second pulse on flush cycle 1 extends flush_out to 3 total cycles.
//  T5 r0: ZERO_REG=1, issue wen rd=0, then read rs1=0 -> no stall; pending_out=0.
//  T6 reset: assert rst_n_in=0 with pending=16'hFFFF, mul_busy=1, state FLUSH
//     -> all outputs 0 asynchronously; first instruction after release issues.

Source files
------------

// File: rtl/hazard_issue_ctrl.sv
// Purpose: ID/EX interlock - register scoreboard (RAW/WAW), multiplier sequencing, post-redirect flush window.
// Latency: issue_out/stall_out are combinational in the ID cycle; scoreboard, mul_busy and flush update on the next edge.
// Backpressure: stall_out holds PC and IF/ID while a hazard or the multiplier blocks issue; flush_out bubbles IF/ID and ID/EX.
module hazard_issue_ctrl #(
  parameter int NREG      = 16,
  parameter int AW        = 4,
  parameter int MUL_LAT   = 3,
  parameter int FLUSH_CYC = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            id_valid_in,
  input  logic [AW-1:0]   id_rs1_in,
  input  logic            id_rs1_use_in,
  input  logic [AW-1:0]   id_rs2_in,
  input  logic            id_rs2_use_in,
  input  logic [AW-1:0]   id_rd_in,
  input  logic            id_wen_in,
  input  logic            id_mul_in,
  input  logic            redirect_in,
  input  logic            wb_wen_in,
  input  logic [AW-1:0]   wb_rd_in,
  output logic            issue_out,
  output logic            stall_out,
  output logic            flush_out,
  output logic            mul_busy_out,
  output logic [NREG-1:0] pending_out
);

  // Counter widths sized to hold LAT-1, never narrower than one bit.
  localparam int MCW = (MUL_LAT   > 2) ? $clog2(MUL_LAT)   : 1;
  localparam int FCW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;
  logic [NREG-1:0]  pend_q, pend_d;

  logic [NREG-1:0]  clr_vec;
  logic [NREG-1:0]  set_vec;
  logic [NREG-1:0]  pend_eff;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             rd_hit;
  logic             mul_busy;
  logic             haz;
  logic             idle_slot;

  // Writeback clear vector and the scoreboard as seen by ID: a register
  // committing this cycle is already bypassed, so it no longer blocks.
  always_comb begin
    clr_vec  = '0;
    pend_eff = '0;
    for (int r = 0; r < NREG; r++) begin
      clr_vec[r]  = wb_wen_in && (wb_rd_in == AW'(r));
      pend_eff[r] = pend_q[r] && !clr_vec[r];
      if ((ZERO_REG != 0) && (r == 0)) begin
        pend_eff[r] = 1'b0;
      end
    end
  end

  // Hazard detection: source RAW, destination WAW, and ALU occupied by the multiplier.
  always_comb begin
    rs1_hit   = id_rs1_use_in && pend_eff[id_rs1_in];
    rs2_hit   = id_rs2_use_in && pend_eff[id_rs2_in];
    rd_hit    = id_wen_in     && pend_eff[id_rd_in];
    mul_busy  = (mul_cnt_q != '0);
    haz       = id_valid_in && (rs1_hit || rs2_hit || rd_hit || mul_busy);
    // Redirect outranks the flush window, which outranks data hazards.
    idle_slot = id_valid_in && !redirect_in && (state_q == ST_IDLE);
    issue_out = idle_slot && !haz;
    stall_out = idle_slot && haz;
  end

  // Scoreboard next state: clear on writeback, then set on issue so a same-cycle set wins.
  always_comb begin
    set_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      set_vec[r] = issue_out && id_wen_in && (id_rd_in == AW'(r));
      if ((ZERO_REG != 0) && (r == 0)) begin
        set_vec[r] = 1'b0;
      end
    end
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  // Multiplier occupancy: reload on MUL issue, otherwise count down to zero.
  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (issue_out && id_mul_in) begin
      mul_cnt_d = MCW'(MUL_LAT - 1);
    end else if (mul_cnt_q != '0) begin
      mul_cnt_d = mul_cnt_q - MCW'(1);
    end
  end

  // Flush FSM next state: any redirect (re)starts the window; otherwise drain it.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (redirect_in) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = FCW'(FLUSH_CYC - 1);
    end else if (state_q == ST_FLUSH) begin
      if (flush_cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        flush_cnt_d = flush_cnt_q - FCW'(1);
      end
    end
  end

  // State registers; reset discards every outstanding write, MUL and flush.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      mul_cnt_q   <= '0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mul_cnt_q   <= mul_cnt_d;
      pend_q      <= pend_d;
    end
  end

  // Registered status outputs.
  always_comb begin
    flush_out    = (state_q == ST_FLUSH);
    mul_busy_out = mul_busy;
    pending_out  = pend_q;
  end

`ifndef SYNTHESIS
  // Issue and stall are mutually exclusive by construction.
  a_issue_stall_excl: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(issue_out && stall_out));
  // A hardwired zero register must never appear pending.
  a_zero_never_pending: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (ZERO_REG == 0) || !pend_q[0]);
`endif

endmodule
